// File: rtl/display_pkg.sv
// Shared constants for the R11 seven-segment display stage: the register
// index that is mirrored on the display and the active-low hex glyph table.
package display_pkg;

  // Architectural register shown on the display (R11).
  localparam logic [3:0] REG_DISPLAY_IDX = 4'hB;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}; element i is the glyph for
  // hex digit i. b and d are the lowercase forms so they differ from 8 and 0.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Glyph lookup for one nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup; every nibble value has a glyph.
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    seg_o = SEG_BLANK;
    seg_o = hex_glyph(nibble_i);
  end

endmodule

// File: rtl/reg_display_scan.sv
// Board display stage: snapshots R11 one cycle after each architectural
// write, scans one 16-bit half of the snapshot across a 4-digit multiplexed
// seven-segment display, flips halves on a debounced page button, and mirrors
// the controller state on LEDs. All outputs are registered.
module reg_display_scan
  import display_pkg::*;
#(
  parameter int DIGIT_PERIOD    = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RegDisplay,
  input  logic        RegWrite,
  input  logic [3:0]  Rd,
  input  logic [3:0]  state,
  input  logic        page_btn,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [3:0]  led,
  output logic        page
);

  localparam int DIV_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  // Capture path
  logic        cap_pend_q;
  logic [31:0] snap_q;

  // Button path
  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            db_level_prev_q;
  logic            page_q, page_d;

  // Scan path
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       digit_q, digit_d;

  // Display datapath
  logic [15:0] half;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [3:0]  an_d;
  logic        dp_d;

  // Output registers
  logic [6:0] seg_q;
  logic [3:0] an_q;
  logic       dp_q;
  logic [3:0] led_q;

  // Next-state logic for the scan counter, debouncer and page toggle.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    digit_d    = digit_q;
    db_cnt_d   = '0;
    db_level_d = db_level_q;

    if (div_q == DIV_LAST) begin
      div_d   = '0;
      digit_d = digit_q + 2'd1;
    end

    // The count only runs while the synced level disagrees with the accepted
    // level; any cycle of agreement (a bounce) drops it back to zero.
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Only the press edge of the debounced level flips the page.
    page_d = page_q ^ (db_level_q & ~db_level_prev_q);
  end

  // Select the active half and the active digit's nibble, then decode.
  assign half   = page_q ? snap_q[31:16] : snap_q[15:0];
  assign nibble = half[4*digit_q +: 4];

  hex7seg u_hex7seg (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  assign an_d = ~(4'b0001 << digit_q);
  assign dp_d = ~((digit_q == 2'd3) & page_q);

  // Capture: the register file is written on the R11-write edge, so the new
  // value is sampled one cycle later. Back-to-back writes keep cap_pend high.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_pend_q <= 1'b0;
      // NOTE: the snapshot is an ordinary register, not a memory, and is
      // cleared so the display shows 0000 out of reset.
      snap_q     <= '0;
    end else begin
      cap_pend_q <= RegWrite && (Rd == REG_DISPLAY_IDX);
      if (cap_pend_q) begin
        snap_q <= RegDisplay;
      end
    end
  end

  // Button synchronizer, debouncer and page register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      db_cnt_q        <= '0;
      db_level_q      <= 1'b0;
      db_level_prev_q <= 1'b0;
      page_q          <= 1'b0;
    end else begin
      sync1_q         <= page_btn;
      sync2_q         <= sync1_q;
      db_cnt_q        <= db_cnt_d;
      db_level_q      <= db_level_d;
      db_level_prev_q <= db_level_q;
      page_q          <= page_d;
    end
  end

  // Digit scan counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      digit_q <= 2'd0;
    end else begin
      div_q   <= div_d;
      digit_q <= digit_d;
    end
  end

  // Registered display and LED outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= hex_glyph(4'h0);
      an_q  <= 4'b1110;
      dp_q  <= 1'b1;
      led_q <= 4'h0;
    end else begin
      seg_q <= glyph;
      an_q  <= an_d;
      dp_q  <= dp_d;
      led_q <= state;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign led  = led_q;
  assign page = page_q;

endmodule

// File: tb/tb_reg_display_scan.sv
// Self-checking bench for reg_display_scan with a short digit period and
// debounce window so every scenario fits in a few hundred cycles.
module tb_reg_display_scan;

  localparam int P = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RegDisplay;
  logic        RegWrite;
  logic [3:0]  Rd;
  logic [3:0]  state;
  logic        page_btn;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [3:0]  led;
  logic        page;

  int checks   = 0;
  int failures = 0;

  reg_display_scan #(
    .DIGIT_PERIOD    (P),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RegDisplay (RegDisplay),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .state      (state),
    .page_btn   (page_btn),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .led        (led),
    .page       (page)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // R11 (or other register) write: write cycle, then the value the register
  // file presents, then an unrelated value that must never be captured.
  task automatic do_write(input logic [31:0] val, input logic [3:0] rd);
    @(negedge clk);
    RegWrite = 1'b1;
    Rd       = rd;
    @(negedge clk);
    RegWrite   = 1'b0;
    Rd         = 4'h0;
    RegDisplay = val;
    @(negedge clk);
    RegDisplay = 32'hDEAD_BEEF;
  endtask

  // Visit each digit in turn and compare its glyph and decimal point.
  // segs = {d3,d2,d1,d0}; dps bit d is the expected dp for digit d.
  task automatic check_digits(input string tag, input logic [27:0] segs,
                              input logic [3:0] dps);
    logic [3:0] want_an;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      int n;
      n = 0;
      want_an = ~(4'b0001 << d);
      while (an !== want_an && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        check($sformatf("%s an_timeout_d%0d", tag, d), {28'h0, an}, {28'h0, want_an});
      end else begin
        check($sformatf("%s seg_d%0d", tag, d), {25'h0, seg}, {25'h0, segs[7*d +: 7]});
        check($sformatf("%s dp_d%0d", tag, d), {31'h0, dp}, {31'h0, dps[d]});
      end
    end
  endtask

  typedef struct {
    logic [31:0] value;
    logic [3:0]  rd;
    logic [27:0] exp_seg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] an_seq[4];
    logic       prev_page;
    int         toggles;
    int         n;

    // Hand-computed glyphs, digits listed d3,d2,d1,d0.
    vecs[0] = '{32'h1234ABCD, 4'hB, {7'h08, 7'h03, 7'h46, 7'h21}};  // A b C d
    vecs[1] = '{32'h0000FFFF, 4'hB, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};  // F F F F
    vecs[2] = '{32'h00005555, 4'hA, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};  // R10 write: unchanged
    vecs[3] = '{32'h00009876, 4'hB, {7'h10, 7'h00, 7'h78, 7'h02}};  // 9 8 7 6
    vecs[4] = '{32'h00005432, 4'hB, {7'h12, 7'h19, 7'h30, 7'h24}};  // 5 4 3 2
    vecs[5] = '{32'h0000E010, 4'hB, {7'h06, 7'h40, 7'h79, 7'h40}};  // E 0 1 0
    vecs[6] = '{32'h12340000, 4'hB, {7'h40, 7'h40, 7'h40, 7'h40}};  // lower half 0000

    an_seq[0] = 4'b1101;
    an_seq[1] = 4'b1011;
    an_seq[2] = 4'b0111;
    an_seq[3] = 4'b1110;

    reset      = 1'b1;
    RegDisplay = 32'h0;
    RegWrite   = 1'b0;
    Rd         = 4'h0;
    state      = 4'h0;
    page_btn   = 1'b0;

    // Reset values after two reset cycles.
    @(negedge clk);
    @(negedge clk);
    check("reset an", {28'h0, an}, 32'hE);
    check("reset seg", {25'h0, seg}, 32'h40);
    check("reset dp", {31'h0, dp}, 32'h1);
    check("reset led", {28'h0, led}, 32'h0);
    check("reset page", {31'h0, page}, 32'h0);
    reset = 1'b0;

    // Scan order and dwell: each digit lit for exactly P cycles.
    n = 0;
    while (an === 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4 * P; i++) begin
      check($sformatf("scan an cycle %0d", i), {28'h0, an}, {28'h0, an_seq[i / P]});
      @(negedge clk);
    end

    // LEDs lag state by one cycle.
    state = 4'h5;
    check("led before edge", {28'h0, led}, 32'h0);
    @(negedge clk);
    check("led after edge", {28'h0, led}, 32'h5);
    state = 4'hA;
    @(negedge clk);
    check("led follows", {28'h0, led}, 32'hA);

    // Table of captures, page 0.
    for (int v = 0; v < 7; v++) begin
      do_write(vecs[v].value, vecs[v].rd);
      check_digits($sformatf("vec%0d", v), vecs[v].exp_seg, 4'b1111);
    end

    // Back-to-back R11 writes: the second capture wins.
    @(negedge clk);
    RegWrite = 1'b1;
    Rd       = 4'hB;
    @(negedge clk);
    RegDisplay = 32'h0000_1111;
    @(negedge clk);
    RegWrite   = 1'b0;
    Rd         = 4'h0;
    RegDisplay = 32'h0000_2222;
    @(negedge clk);
    RegDisplay = 32'h0000_3333;
    check_digits("b2b", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // Page: hold the button 10 cycles; page rises exactly 6 edges after press.
    do_write(32'h1234ABCD, 4'hB);
    @(negedge clk);
    prev_page = page;
    toggles   = 0;
    page_btn  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (page !== prev_page) toggles++;
      prev_page = page;
      if (i == 5) check("page before debounce", {31'h0, page}, 32'h0);
      if (i == 6) check("page after debounce", {31'h0, page}, 32'h1);
      if (i == 10) page_btn = 1'b0;
    end
    check("page toggles once", toggles, 32'd1);
    check("page held after release", {31'h0, page}, 32'h1);
    check_digits("page1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0111);

    // Bounce: toggling every 2 cycles never satisfies the debounce window.
    for (int i = 0; i < 20; i++) begin
      page_btn = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    page_btn = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("bounce page unchanged", {31'h0, page}, 32'h1);

    // Reset on the cycle after an R11 write: the pending capture is lost.
    @(negedge clk);
    RegWrite = 1'b1;
    Rd       = 4'hB;
    @(negedge clk);
    RegWrite   = 1'b0;
    Rd         = 4'h0;
    reset      = 1'b1;
    RegDisplay = 32'hCAFE_F00D;
    @(negedge clk);
    reset = 1'b0;
    check("midcap an", {28'h0, an}, 32'hE);
    check("midcap page", {31'h0, page}, 32'h0);
    check_digits("midcap", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
